// File: rtl/stream_pair_packer.sv
// Captures P/Q word pairs into a small FIFO and serialises each pair as two
// valid/ready beats (P, then Q with last). Pairs arriving while full are dropped and counted.
module stream_pair_packer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_p,
   input  logic [WIDTH-1:0]           in_q,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   output logic [7:0]                 drop_count,
   output logic [WIDTH-1:0]           checksum
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, EMIT_P, EMIT_Q} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem_p [DEPTH];
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [WIDTH-1:0] hp, hq;
   logic             full, empty, push, pop, fire;

   // Fullness comes from the registered level only, so a same-cycle pop never frees a slot.
   assign full  = (fifo_level == LW'(DEPTH));
   assign empty = (fifo_level == '0);
   assign push  = in_valid && !full;
   assign pop   = !empty && ((state == IDLE) || (state == EMIT_Q && out_ready));
   assign fire  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_p[wptr] <= in_p;
         mem_q[wptr] <= in_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         fifo_level <= '0;
         hp         <= '0;
         hq         <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
         checksum   <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         fifo_level <= fifo_level + LW'(push) - LW'(pop);

         if (in_valid && full) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         end

         if (fire) checksum <= checksum ^ out_data;

         // Output regs are loaded alongside the state so nothing downstream sees a comb path.
         case (state)
            IDLE: begin
               if (pop) begin
                  hp        <= mem_p[rptr];
                  hq        <= mem_q[rptr];
                  out_valid <= 1'b1;
                  out_data  <= mem_p[rptr];
                  out_last  <= 1'b0;
                  state     <= EMIT_P;
               end
            end
            EMIT_P: begin
               if (out_ready) begin
                  out_data <= hq;
                  out_last <= 1'b1;
                  state    <= EMIT_Q;
               end
            end
            EMIT_Q: begin
               if (out_ready) begin
                  if (pop) begin
                     hp        <= mem_p[rptr];
                     hq        <= mem_q[rptr];
                     out_valid <= 1'b1;
                     out_data  <= mem_p[rptr];
                     out_last  <= 1'b0;
                     state     <= EMIT_P;
                  end else begin
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_last  <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               out_valid <= 1'b0;
               out_data  <= '0;
               out_last  <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_stream_pair_packer.sv
// Directed scenarios for stream_pair_packer; expected beats go into a queue
// that a negedge monitor drains on every accepted output beat.
module tb_stream_pair_packer;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] in_p, in_q;
   logic [WIDTH-1:0] out_data;
   logic             out_valid, out_ready, out_last;
   logic [2:0]       fifo_level;
   logic             overflow;
   logic [7:0]       drop_count;
   logic [WIDTH-1:0] checksum;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;
   beat_t exp_q [$];

   stream_pair_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_p(in_p), .in_q(in_q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count), .checksum(checksum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected none", out_data, out_last);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(e.data));
            chk("beat_last", 32'(out_last), 32'(e.last));
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_pair(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
      exp_q.push_back('{data: p, last: 1'b0});
      exp_q.push_back('{data: q, last: 1'b1});
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_p = '0; in_q = '0;
      cyc();
      exp_q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drops", 32'(drop_count), 32'd0);
      chk("rst_checksum", 32'(checksum), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      int vld_seq;
      int max_lvl;

      do_reset();

      // 1: single pair, ready high
      out_ready = 1'b1; in_valid = 1'b1; in_p = 16'h1234; in_q = 16'h00FF;
      exp_pair(16'h1234, 16'h00FF);
      cyc();
      in_valid = 1'b0;
      chk("s1_c1_valid", 32'(out_valid), 32'd0);
      cyc();
      chk("s1_p_valid", 32'(out_valid), 32'd1);
      chk("s1_p_data", 32'(out_data), 32'h1234);
      chk("s1_p_last", 32'(out_last), 32'd0);
      cyc();
      chk("s1_q_data", 32'(out_data), 32'h00FF);
      chk("s1_q_last", 32'(out_last), 32'd1);
      cyc();
      chk("s1_idle_valid", 32'(out_valid), 32'd0);
      chk("s1_checksum", 32'(checksum), 32'h12CB);

      // 2: backpressure holds the P beat
      do_reset();
      in_valid = 1'b1; in_p = 16'h1234; in_q = 16'h00FF;
      exp_pair(16'h1234, 16'h00FF);
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("s2_hold_valid", 32'(out_valid), 32'd1);
         chk("s2_hold_data", 32'(out_data), 32'h1234);
      end
      out_ready = 1'b1;
      cyc(3);
      chk("s2_idle_valid", 32'(out_valid), 32'd0);
      chk("s2_checksum", 32'(checksum), 32'h12CB);
      chk("s2_queue_empty", 32'(exp_q.size()), 32'd0);

      // 3: overflow -- 10 pairs, only 0..4 survive
      do_reset();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_p = 16'h1000 + 16'(i); in_q = 16'h2000 + 16'(i);
         if (i < 5) exp_pair(in_p, in_q);
         cyc();
      end
      in_valid = 1'b0;
      chk("s3_level", 32'(fifo_level), 32'd4);
      chk("s3_drops", 32'(drop_count), 32'd5);
      chk("s3_overflow", 32'(overflow), 32'd1);
      chk("s3_hold_data", 32'(out_data), 32'h1000);
      out_ready = 1'b1;
      cyc(12);
      chk("s3_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("s3_idle_valid", 32'(out_valid), 32'd0);
      chk("s3_checksum", 32'(checksum), 32'h3000);
      chk("s3_overflow_sticky", 32'(overflow), 32'd1);

      // 4: back-to-back pairs at 2-cycle spacing, no bubble
      do_reset();
      out_ready = 1'b1;
      vld_seq = 0; max_lvl = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0 || i == 2 || i == 4) begin
            in_valid = 1'b1; in_p = 16'hA000 + 16'(i); in_q = 16'hB000 + 16'(i);
            exp_pair(in_p, in_q);
         end else begin
            in_valid = 1'b0;
         end
         cyc();
         vld_seq = (vld_seq << 1) | int'(out_valid);
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
      chk("s4_valid_pattern", 32'(vld_seq), 32'b01111110);
      chk("s4_max_level", 32'(max_lvl), 32'd1);
      chk("s4_queue_empty", 32'(exp_q.size()), 32'd0);

      // 5: drop counter saturates at 255
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 305; i++) begin
         in_p = 16'(i); in_q = 16'(~i);
         cyc();
      end
      chk("s5_drops_sat", 32'(drop_count), 32'd255);
      chk("s5_overflow", 32'(overflow), 32'd1);
      cyc(5);
      in_valid = 1'b0;
      chk("s5_drops_hold", 32'(drop_count), 32'd255);
      chk("s5_level", 32'(fifo_level), 32'd4);

      // 6: reset while in EMIT_Q with two pairs queued
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_p = 16'hC000 + 16'(i); in_q = 16'hD000 + 16'(i);
         cyc();
      end
      in_valid = 1'b0;
      exp_q.push_back('{data: 16'hC000, last: 1'b0});
      chk("s6_pre_level", 32'(fifo_level), 32'd2);
      out_ready = 1'b1;
      cyc();
      chk("s6_in_q_last", 32'(out_last), 32'd1);
      chk("s6_in_q_data", 32'(out_data), 32'hD000);
      out_ready = 1'b0; rst_n = 1'b0;
      cyc();
      exp_q.delete();
      chk("s6_rst_valid", 32'(out_valid), 32'd0);
      chk("s6_rst_data", 32'(out_data), 32'd0);
      chk("s6_rst_last", 32'(out_last), 32'd0);
      chk("s6_rst_level", 32'(fifo_level), 32'd0);
      chk("s6_rst_checksum", 32'(checksum), 32'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      cyc(6);
      chk("s6_no_stale", 32'(out_valid), 32'd0);
      chk("s6_checksum_after", 32'(checksum), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/stream_pair_packer.md
# stream_pair_packer

Downstream consumer of the dual-branch pipeline stage. Each cycle it may capture the paired `p`/`q` branch words into a small FIFO. It then serialises each pair onto a single valid/ready output stream as two beats, `p` then `q`, with `last` marking `q`. The upstream stage cannot stall, so the block drops pairs on overflow and counts them, and keeps a running XOR checksum of delivered beats for bring-up.

## Interface
- `WIDTH`, 16, width of each branch word and of `out_data`/`checksum`
- `DEPTH`, 4, FIFO depth in pairs; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  pair on `in_p`/`in_q` is valid this cycle
- `in_p`  in  WIDTH  branch P word
- `in_q`  in  WIDTH  branch Q word
- `out_data`  out  WIDTH  serialised beat
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_last`  out  1  high on the Q beat of a pair
- `fifo_level`  out  $clog2(DEPTH)+1  pairs currently stored, excluding the pair in the hold register
- `overflow`  out  1  sticky; a pair was dropped
- `drop_count`  out  8  dropped pairs, saturating at 255
- `checksum`  out  WIDTH  XOR of all accepted beats

## Operation
- **Write side**
  - `in_valid && level<DEPTH`: push `{in_p,in_q}`.
  - `in_valid && level==DEPTH`: drop the pair, set `overflow`, and increment `drop_count` unless it is 255.
  - Fullness is judged on the registered level. A push while full is dropped even if a pop occurs in the same cycle.
- **Read side.** The FSM has states IDLE, EMIT_P and EMIT_Q, plus a hold register `{hp,hq}`.
  - **IDLE**
    - Outputs: `out_valid=0`, `out_data=0`, `out_last=0`.
    - If FIFO non-empty: pop the head into hold and go to EMIT_P.
  - **EMIT_P**
    - Outputs: `out_valid=1`, `out_data=hp`, `out_last=0`.
    - On `out_ready`: go to EMIT_Q.
  - **EMIT_Q**
    - Outputs: `out_valid=1`, `out_data=hq`, `out_last=1`.
    - On `out_ready` with FIFO non-empty: pop into hold and go to EMIT_P (no bubble).
    - On `out_ready` with FIFO empty: go to IDLE.
  - Without `out_ready`, the state, `out_data` and `out_last` stay stable.
- **Simultaneous push and pop:** allowed. `fifo_level` is unchanged, and pointers wrap modulo DEPTH.
- **Checksum:** on every `out_valid && out_ready`, `checksum <= checksum ^ out_data`. It wraps naturally (XOR), with no clear other than reset.
- **Sustained rate:** the output carries at most one pair per 2 cycles. Upstream rates above that fill the FIFO and drop pairs by design.

## Timing
- **Reset** (`rst_n` low at a rising edge), takes effect at that edge:
  - FSM goes to IDLE.
  - FIFO pointers and `fifo_level` are cleared; the hold register is cleared.
  - `out_valid=0`, `out_data=0`, `out_last=0`, `overflow=0`, `drop_count=0`, `checksum=0`.
  - Any in-flight pair is discarded, including one mid-EMIT_Q.
  - `in_valid` is ignored while `rst_n` is low.
- **Latency:** a pair sampled at edge N enters the FIFO and IDLE pops it at edge N+1. The P beat is visible from edge N+1 (cycle N+2 relative to sampling), and the Q beat one cycle after the P beat is accepted.
- **Registered outputs:** all outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` or `in_valid` to any output.
- **Status timing:** `overflow` and `drop_count` update at the edge that samples the dropped pair.

## Test plan
All scenarios use WIDTH=16, DEPTH=4.

1. **Single pair.** `in_valid` for one cycle (cycle 0) with `p=0x1234`, `q=0x00FF`; `out_ready=1` → cycle 2 shows `0x1234` with `last=0`, cycle 3 shows `0x00FF` with `last=1`, cycle 4 has `out_valid=0`; final `checksum=0x12CB`.
2. **Backpressure.** Repeat scenario 1 with `out_ready=0` for cycles 2–6 → `out_data` holds `0x1234` with `out_valid=1` throughout; after release, beats complete in order and `checksum=0x12CB`.
3. **Overflow.** `out_ready=0` and `in_valid=1` for 10 consecutive cycles with distinct pairs → the hold register holds pair 0, `fifo_level=4`, `drop_count=5`, `overflow=1`. After releasing `out_ready`, exactly 5 pairs (10 beats) emerge, namely pairs 0–4.
4. **Back-to-back.** 3 pairs at a 2-cycle spacing with `out_ready=1` → 6 contiguous valid beats with no bubble, `out_last` on beats 2, 4 and 6, and `fifo_level` never exceeds 1.
5. **Saturation.** `out_ready=0` and `in_valid=1` for 305 cycles → `drop_count=255` and holds there; `overflow` stays 1.
6. **Reset mid-stream.** Assert `rst_n=0` for one edge while in EMIT_Q with 2 pairs queued → the next cycle shows all outputs 0 and `fifo_level=0`; no stale beat appears afterward.
